// File: rtl/regfile_pkg.sv
// Shared defaults and base types for the register file slice.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int AW           = $clog2(NREG_DEFAULT);

  typedef logic [AW-1:0]           reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issues reserve a destination, committed writes release it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  parameter  int NWR  = 1,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NWR-1:0]          i_clr_en,
  input  logic [NWR-1:0][AW-1:0]  i_clr_addr,
  input  logic                    i_iss_valid,
  input  logic [AW-1:0]           i_iss_rd,
  output logic [NREG-1:0]         o_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // NOTE: always_comb starts from a full default so no path leaves busy_d unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (i_clr_en[k]) busy_d[i_clr_addr[k]] = 1'b0;
    end
    // Set after clear: a same-cycle issue is the newer producer and keeps the bit.
    if (i_iss_valid) busy_d[i_iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-to-read bypass and a busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREG   = NREG_DEFAULT,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NRD-1:0][AW-1:0]   i_rs_addr,
  output logic [NRD-1:0][XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]           o_rs_busy,
  input  logic [NWR-1:0]           i_rd_wren,
  input  logic [NWR-1:0][AW-1:0]   i_rd_addr,
  input  logic [NWR-1:0][XLEN-1:0] i_rd_data,
  input  logic                     i_iss_valid,
  input  logic [AW-1:0]            i_iss_rd,
  output logic [NREG-1:0]          o_busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NWR-1:0]  wr_act;
  logic [NREG-1:0] busy;

  // Gating with reset keeps bypass and storage inert while reset is held.
  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wr_act[k] = i_rd_wren[k] && (i_rd_addr[k] != '0) && i_rst_n;
    end
  end

  // NOTE: the array is flop-based with an async clear, so it is reset like any other state.
  // NOTE: non-blocking writes in port order make the highest-numbered port win a collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_act[k]) regs[i_rd_addr[k]] <= i_rd_data[k];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr_en    (wr_act),
    .i_clr_addr  (i_rd_addr),
    .i_iss_valid (i_iss_valid && i_rst_n),
    .i_iss_rd    (i_iss_rd),
    .o_busy      (busy)
  );

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      o_rs_data[j] = regs[i_rs_addr[j]];
      o_rs_busy[j] = busy[i_rs_addr[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_act[k] && (i_rd_addr[k] == i_rs_addr[j])) begin
            o_rs_data[j] = i_rd_data[k];
            o_rs_busy[j] = 1'b0;
          end
        end
      end
    end
  end

  assign o_busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypass and non-bypass instances share stimulus and one array model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b1;
  reg_addr_t [NRD-1:0]     rs_addr;
  logic [NRD-1:0][31:0]    rs_data_b, rs_data_n;
  logic [NRD-1:0]          rs_busy_b, rs_busy_n;
  logic [NWR-1:0]          rd_wren;
  reg_addr_t [NWR-1:0]     rd_addr;
  logic [NWR-1:0][31:0]    rd_data;
  logic                    iss_valid;
  reg_addr_t               iss_rd;
  logic [31:0]             busy_vec_b, busy_vec_n;

  xdata_t      m_mem [32];
  logic [31:0] m_busy;
  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_addr(rs_addr), .o_rs_data(rs_data_b),
    .o_rs_busy(rs_busy_b), .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_busy_vec(busy_vec_b));

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_dut_n (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rs_addr(rs_addr), .o_rs_data(rs_data_n),
    .o_rs_busy(rs_busy_n), .i_rd_wren(rd_wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .o_busy_vec(busy_vec_n));

  // ---------------- reference model ----------------
  function automatic xdata_t exp_data(reg_addr_t a, bit byp);
    xdata_t v = m_mem[a];
    if (byp && a != 0 && i_rst_n)
      for (int k = 0; k < NWR; k++)
        if (rd_wren[k] && rd_addr[k] == a) v = rd_data[k];
    return v;
  endfunction

  function automatic logic exp_busy(reg_addr_t a, bit byp);
    logic hit = 1'b0;
    if (byp && a != 0 && i_rst_n)
      for (int k = 0; k < NWR; k++)
        if (rd_wren[k] && rd_addr[k] == a) hit = 1'b1;
    return m_busy[a] & ~hit;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  task automatic model_commit();
    for (int k = 0; k < NWR; k++)
      if (rd_wren[k] && rd_addr[k] != 0) begin
        m_mem[rd_addr[k]]  = rd_data[k];
        m_busy[rd_addr[k]] = 1'b0;
      end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic idle();
    rd_wren = '0; rd_addr = '0; rd_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs_addr = '0;
  endtask

  task automatic step();
    @(posedge i_clk);
    if (i_rst_n) model_commit();
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rd_wren = 2'b01; rd_addr[0] = 5'd4; rd_data[0] = 32'h0000CAFE;
    iss_valid = 1'b1; iss_rd = 5'd4; rs_addr[0] = 5'd4;
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'h0) begin n_err++; $display("FAIL rst_rs_data got=%h exp=0", rs_data_b[0]); end
    n_cmp++; if (rs_busy_b[0] !== 1'b0) begin n_err++; $display("FAIL rst_rs_busy got=%b exp=0", rs_busy_b[0]); end
    n_cmp++; if (busy_vec_b !== 32'h0) begin n_err++; $display("FAIL rst_busy_vec got=%h exp=0", busy_vec_b); end
    step();
    i_rst_n = 1'b1; idle(); rs_addr[0] = 5'd4;
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'h0) begin n_err++; $display("FAIL rst_ignored_wr got=%h exp=0", rs_data_b[0]); end
    n_cmp++; if (busy_vec_b !== 32'h0) begin n_err++; $display("FAIL rst_ignored_iss got=%h exp=0", busy_vec_b); end
    rd_wren = 2'b01; rd_addr[0] = 5'd5; rd_data[0] = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd6;
    step();
    idle(); rs_addr[0] = 5'd5;
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL x5_written got=%h exp=deadbeef", rs_data_b[0]); end
    n_cmp++; if (busy_vec_b !== 32'h40) begin n_err++; $display("FAIL x6_busy got=%h exp=00000040", busy_vec_b); end
    i_rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (rs_data_b[0] !== 32'h0 || rs_data_n[0] !== 32'h0) begin n_err++; $display("FAIL async_rst_x5 got=%h/%h exp=0", rs_data_b[0], rs_data_n[0]); end
    n_cmp++; if (busy_vec_b !== 32'h0) begin n_err++; $display("FAIL async_rst_busy got=%h exp=0", busy_vec_b); end
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_x0();
    idle(); rd_wren = 2'b01; rd_addr[0] = 5'd0; rd_data[0] = 32'hFFFFFFFF;
    iss_valid = 1'b1; iss_rd = 5'd0; rs_addr[0] = 5'd0;
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'h0) begin n_err++; $display("FAIL x0_no_bypass got=%h exp=0", rs_data_b[0]); end
    step();
    idle();
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'h0) begin n_err++; $display("FAIL x0_read got=%h exp=0", rs_data_b[0]); end
    n_cmp++; if (rs_busy_b[0] !== 1'b0 || busy_vec_b[0] !== 1'b0) begin n_err++; $display("FAIL x0_busy got=%b/%b exp=0", rs_busy_b[0], busy_vec_b[0]); end
  endtask

  task automatic test_bypass();
    idle(); rd_wren = 2'b01; rd_addr[0] = 5'd7; rd_data[0] = 32'h11;
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    idle(); rd_wren = 2'b01; rd_addr[0] = 5'd7; rd_data[0] = 32'h12345678; rs_addr[0] = 5'd7;
    #1;
    n_cmp++; if (rs_data_b[0] !== 32'h12345678) begin n_err++; $display("FAIL byp_data got=%h exp=12345678", rs_data_b[0]); end
    n_cmp++; if (rs_busy_b[0] !== 1'b0) begin n_err++; $display("FAIL byp_busy_mask got=%b exp=0", rs_busy_b[0]); end
    n_cmp++; if (rs_data_n[0] !== 32'h11) begin n_err++; $display("FAIL nobyp_old got=%h exp=00000011", rs_data_n[0]); end
    n_cmp++; if (rs_busy_n[0] !== 1'b1) begin n_err++; $display("FAIL nobyp_busy got=%b exp=1", rs_busy_n[0]); end
    step();
    idle(); rs_addr[0] = 5'd7;
    #1;
    n_cmp++; if (rs_data_n[0] !== 32'h12345678) begin n_err++; $display("FAIL nobyp_next got=%h exp=12345678", rs_data_n[0]); end
    n_cmp++; if (rs_busy_n[0] !== 1'b0) begin n_err++; $display("FAIL nobyp_busy_clr got=%b exp=0", rs_busy_n[0]); end
  endtask

  task automatic test_dual_write();
    idle(); rd_wren = 2'b11; rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
    rd_data[0] = 32'hA; rd_data[1] = 32'hB; rs_addr[1] = 5'd3;
    #1;
    n_cmp++; if (rs_data_b[1] !== 32'hB) begin n_err++; $display("FAIL dual_byp got=%h exp=0000000b", rs_data_b[1]); end
    step();
    idle(); rs_addr[1] = 5'd3;
    #1;
    n_cmp++; if (rs_data_b[1] !== 32'hB || rs_data_n[1] !== 32'hB) begin n_err++; $display("FAIL dual_x3 got=%h/%h exp=0000000b", rs_data_b[1], rs_data_n[1]); end
  endtask

  task automatic test_scoreboard();
    idle(); iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    idle(); rs_addr[0] = 5'd9;
    #1;
    n_cmp++; if (rs_busy_b[0] !== 1'b1 || busy_vec_b[9] !== 1'b1) begin n_err++; $display("FAIL sb_issue got=%b/%b exp=1", rs_busy_b[0], busy_vec_b[9]); end
    rd_wren = 2'b01; rd_addr[0] = 5'd9; rd_data[0] = 32'h55;
    step();
    idle(); rs_addr[0] = 5'd9;
    #1;
    n_cmp++; if (rs_busy_b[0] !== 1'b0 || rs_data_b[0] !== 32'h55) begin n_err++; $display("FAIL sb_release got=%b/%h exp=0/00000055", rs_busy_b[0], rs_data_b[0]); end
    iss_valid = 1'b1; iss_rd = 5'd9; rd_wren = 2'b10; rd_addr[1] = 5'd9; rd_data[1] = 32'h77;
    step();
    idle(); rs_addr[0] = 5'd9;
    #1;
    n_cmp++; if (busy_vec_b[9] !== 1'b1 || rs_busy_n[0] !== 1'b1) begin n_err++; $display("FAIL sb_simul_busy got=%b/%b exp=1", busy_vec_b[9], rs_busy_n[0]); end
    n_cmp++; if (rs_data_b[0] !== 32'h77) begin n_err++; $display("FAIL sb_simul_data got=%h exp=00000077", rs_data_b[0]); end
  endtask

  function automatic reg_addr_t rnd_addr();
    return ($urandom_range(0, 3) == 0) ? reg_addr_t'($urandom_range(0, 31))
                                       : reg_addr_t'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      rd_wren = 2'($urandom);
      for (int k = 0; k < NWR; k++) begin
        rd_addr[k] = rnd_addr();
        rd_data[k] = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = rnd_addr();
      for (int j = 0; j < NRD; j++) rs_addr[j] = rnd_addr();
      #1;
      for (int j = 0; j < NRD; j++) begin
        n_cmp++; if (rs_data_b[j] !== exp_data(rs_addr[j], 1'b1)) begin n_err++; $display("FAIL rnd_data_byp c=%0d j=%0d got=%h exp=%h", c, j, rs_data_b[j], exp_data(rs_addr[j], 1'b1)); end
        n_cmp++; if (rs_data_n[j] !== exp_data(rs_addr[j], 1'b0)) begin n_err++; $display("FAIL rnd_data_nobyp c=%0d j=%0d got=%h exp=%h", c, j, rs_data_n[j], exp_data(rs_addr[j], 1'b0)); end
        n_cmp++; if (rs_busy_b[j] !== exp_busy(rs_addr[j], 1'b1)) begin n_err++; $display("FAIL rnd_busy_byp c=%0d j=%0d got=%b exp=%b", c, j, rs_busy_b[j], exp_busy(rs_addr[j], 1'b1)); end
        n_cmp++; if (rs_busy_n[j] !== exp_busy(rs_addr[j], 1'b0)) begin n_err++; $display("FAIL rnd_busy_nobyp c=%0d j=%0d got=%b exp=%b", c, j, rs_busy_n[j], exp_busy(rs_addr[j], 1'b0)); end
      end
      n_cmp++; if (busy_vec_b !== m_busy || busy_vec_n !== m_busy) begin n_err++; $display("FAIL rnd_busy_vec c=%0d got=%h/%h exp=%h", c, busy_vec_b, busy_vec_n, m_busy); end
      step();
    end
  endtask

  initial begin
    idle();
    model_reset();
    #1 i_rst_n = 1'b0;
    @(posedge i_clk);
    #2;
    test_reset();
    test_x0();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
